// File: rtl/load_store_unit.sv
// Load/store unit: aligns byte/half/word/dword accesses onto an XLEN bus, splitting misaligned ones into two beats.
// Latency: resp_valid one cycle after the final mem_resp, or one cycle after acceptance for rejected requests.
// Backpressure: one request in flight; req_ready only while idle, bus strobes held until mem_resp.
module load_store_unit #(
    parameter int XLEN  = 32,
    parameter int SPLIT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_store,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              resp_valid,
    output logic [XLEN-1:0]   resp_rdata,
    output logic              resp_err,
    output logic              mem_read,
    output logic              mem_write,
    output logic [31:0]       mem_address,
    output logic [XLEN-1:0]   mem_wdata,
    output logic [XLEN/8-1:0] mem_byte_enable,
    input  logic [XLEN-1:0]   mem_rdata,
    input  logic              mem_resp
);
    localparam int NB   = XLEN / 8;
    localparam int OFFW = $clog2(NB);

    typedef enum logic [1:0] {IDLE, BEAT1, BEAT2, DONE} state_t;

    state_t            state_q, state_d;
    logic              store_q, store_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [OFFW-1:0]   off_q, off_d;
    logic [3:0]        size_q, size_d;
    logic [31:0]       aligned_q, aligned_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic              err_q, err_d;
    logic [XLEN-1:0]   beat0_q, beat0_d;
    logic [XLEN-1:0]   beat1_q, beat1_d;
    logic [XLEN-1:0]   rdata_q, rdata_d;

    logic [OFFW-1:0]   req_off;
    logic [3:0]        req_size;
    logic [4:0]        req_end;
    logic              req_illegal;
    logic [4:0]        span_end;
    logic [2*XLEN-1:0] wsh;
    logic [2*XLEN-1:0] cat;
    logic [XLEN-1:0]   lmask;
    logic              sign;
    logic [XLEN-1:0]   load_res;
    logic [NB-1:0]     be1, be2;
    logic              beat_act;

    always_comb begin
        req_off     = req_addr[OFFW-1:0];
        req_size    = 4'd1 << req_funct3[1:0];
        req_end     = 5'(req_off) + 5'(req_size);
        req_illegal = (req_funct3 == 3'b111)
                   || ((XLEN == 32) && ((req_funct3 == 3'b011) || (req_funct3 == 3'b110)))
                   || (req_store && req_funct3[2])
                   || ((SPLIT == 0) && (req_end > 5'(NB)));
    end

    // Store data is shifted across a double-width window; the upper half feeds the second beat.
    always_comb begin
        span_end = 5'(off_q) + 5'(size_q);
        wsh      = {{XLEN{1'b0}}, wdata_q} << {off_q, 3'b000};
        cat      = {beat1_q, beat0_q} >> {off_q, 3'b000};
        lmask    = '0;
        be1      = '0;
        be2      = '0;
        for (int i = 0; i < NB; i++) begin
            lmask[8*i +: 8] = (5'(i) < 5'(size_q)) ? 8'hFF : 8'h00;
            be1[i]          = (5'(i) >= 5'(off_q)) && (5'(i) < span_end);
            be2[i]          = (5'(i) + 5'(NB)) < span_end;
        end
        case (funct3_q[1:0])
            2'd0:    sign = cat[7];
            2'd1:    sign = cat[15];
            2'd2:    sign = cat[31];
            default: sign = cat[XLEN-1];
        endcase
        if (store_q || err_q) begin
            load_res = '0;
        end else begin
            load_res = (cat[XLEN-1:0] & lmask) | ((sign && !funct3_q[2]) ? ~lmask : '0);
        end
    end

    always_comb begin
        state_d  = state_q;
        store_d  = store_q;
        funct3_d = funct3_q;
        off_d    = off_q;
        size_d   = size_q;
        aligned_d = aligned_q;
        wdata_d  = wdata_q;
        err_d    = err_q;
        beat0_d  = beat0_q;
        beat1_d  = beat1_q;
        rdata_d  = rdata_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    store_d   = req_store;
                    funct3_d  = req_funct3;
                    off_d     = req_off;
                    size_d    = req_size;
                    aligned_d = {req_addr[31:OFFW], {OFFW{1'b0}}};
                    wdata_d   = req_wdata;
                    err_d     = req_illegal;
                    beat0_d   = '0;
                    beat1_d   = '0;
                    state_d   = req_illegal ? DONE : BEAT1;
                end
            end
            BEAT1: begin
                if (mem_resp) begin
                    beat0_d = mem_rdata;
                    state_d = (span_end > 5'(NB)) ? BEAT2 : DONE;
                end
            end
            BEAT2: begin
                if (mem_resp) begin
                    beat1_d = mem_rdata;
                    state_d = DONE;
                end
            end
            DONE: begin
                rdata_d = load_res;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            store_q   <= 1'b0;
            funct3_q  <= '0;
            off_q     <= '0;
            size_q    <= '0;
            aligned_q <= '0;
            wdata_q   <= '0;
            err_q     <= 1'b0;
            beat0_q   <= '0;
            beat1_q   <= '0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            store_q   <= store_d;
            funct3_q  <= funct3_d;
            off_q     <= off_d;
            size_q    <= size_d;
            aligned_q <= aligned_d;
            wdata_q   <= wdata_d;
            err_q     <= err_d;
            beat0_q   <= beat0_d;
            beat1_q   <= beat1_d;
            rdata_q   <= rdata_d;
        end
    end

    // Outputs decode from the state register only, so reset clears them without waiting for an edge.
    always_comb begin
        beat_act        = (state_q == BEAT1) || (state_q == BEAT2);
        req_ready       = (state_q == IDLE) && rst;
        resp_valid      = (state_q == DONE);
        resp_err        = (state_q == DONE) && err_q;
        resp_rdata      = (state_q == DONE) ? load_res : rdata_q;
        mem_read        = beat_act && !store_q;
        mem_write       = beat_act && store_q;
        mem_address     = '0;
        mem_wdata       = '0;
        mem_byte_enable = '0;
        if (state_q == BEAT1) begin
            mem_address     = aligned_q;
            mem_byte_enable = be1;
            mem_wdata       = store_q ? wsh[XLEN-1:0] : '0;
        end else if (state_q == BEAT2) begin
            mem_address     = aligned_q + 32'(NB);
            mem_byte_enable = be2;
            mem_wdata       = store_q ? wsh[2*XLEN-1:XLEN] : '0;
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit (XLEN=32): byte-addressed memory model drives the bus, scoreboard queues hold
// expected bus beats and responses; a second instance with SPLIT=0 covers misaligned rejection.
module tb_load_store_unit;
    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req_valid, req_ready, req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic        mem_read, mem_write;
    logic [31:0] mem_address, mem_wdata, mem_rdata;
    logic [3:0]  mem_byte_enable;
    logic        mem_resp;

    logic        z_req_valid, z_req_ready, z_req_store;
    logic [2:0]  z_req_funct3;
    logic [31:0] z_req_addr, z_req_wdata;
    logic        z_resp_valid, z_resp_err;
    logic [31:0] z_resp_rdata;
    logic        z_mem_read, z_mem_write;
    logic [31:0] z_mem_address, z_mem_wdata, z_mem_rdata;
    logic [3:0]  z_mem_byte_enable;
    logic        z_mem_resp;

    load_store_unit #(.XLEN(32), .SPLIT(1)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_wdata(mem_wdata), .mem_byte_enable(mem_byte_enable),
        .mem_rdata(mem_rdata), .mem_resp(mem_resp)
    );

    load_store_unit #(.XLEN(32), .SPLIT(0)) dut_nosplit (
        .clk(clk), .rst(rst),
        .req_valid(z_req_valid), .req_ready(z_req_ready), .req_store(z_req_store),
        .req_funct3(z_req_funct3), .req_addr(z_req_addr), .req_wdata(z_req_wdata),
        .resp_valid(z_resp_valid), .resp_rdata(z_resp_rdata), .resp_err(z_resp_err),
        .mem_read(z_mem_read), .mem_write(z_mem_write), .mem_address(z_mem_address),
        .mem_wdata(z_mem_wdata), .mem_byte_enable(z_mem_byte_enable),
        .mem_rdata(z_mem_rdata), .mem_resp(z_mem_resp)
    );

    typedef struct { logic [31:0] addr; logic [3:0] be; logic wr; logic [31:0] wdata; } beat_t;
    typedef struct { logic [31:0] rdata; logic err; } rsp_t;

    beat_t       bq[$];
    rsp_t        rq[$];
    logic [7:0]  mem [logic [31:0]];
    int          n_chk = 0;
    int          n_err = 0;
    int          lat = 1;
    int unsigned cyc = 0;
    int unsigned raise_cyc = 0;
    int unsigned drive_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [7:0] rd_byte(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return a[7:0] ^ {a[3:0], a[11:8]} ^ 8'hA5;
    endfunction

    task automatic set_word(input logic [31:0] a, input logic [31:0] w);
        for (int i = 0; i < 4; i++) mem[a + 32'(i)] = w[8*i +: 8];
    endtask

    // Bus slave: checks each beat against the queue, holds for 'lat' cycles, then returns memory bytes.
    task automatic serve();
        beat_t       e;
        logic [31:0] a0, wd0, word;
        logic [5:0]  ctl0;
        a0   = mem_address;
        wd0  = mem_wdata;
        ctl0 = {mem_byte_enable, mem_read, mem_write};
        chk("one_strobe", 64'(mem_read && mem_write), 64'd0);
        if (bq.size() == 0) begin
            chk("beat_unexpected", 64'd1, 64'd0);
        end else begin
            e = bq.pop_front();
            chk("beat_addr", 64'(a0), 64'(e.addr));
            chk("beat_be", 64'(mem_byte_enable), 64'(e.be));
            chk("beat_wr", 64'({mem_read, mem_write}), e.wr ? 64'd1 : 64'd2);
            if (e.wr) chk("beat_wdata", 64'(wd0), 64'(e.wdata));
        end
        for (int k = 0; k < lat; k++) begin
            @(negedge clk);
            if (!rst) return;
            chk("hold_addr", 64'(mem_address), 64'(a0));
            chk("hold_ctl", 64'({mem_byte_enable, mem_read, mem_write}), 64'(ctl0));
            chk("hold_wdata", 64'(mem_wdata), 64'(wd0));
        end
        for (int i = 0; i < 4; i++) word[8*i +: 8] = rd_byte(a0 + 32'(i));
        mem_rdata = word;
        mem_resp  = 1'b1;
        raise_cyc = cyc;
        @(negedge clk);
        mem_resp  = 1'b0;
        mem_rdata = 32'h0;
    endtask

    initial begin
        mem_resp  = 1'b0;
        mem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            while (rst && (mem_read || mem_write)) serve();
        end
    end

    initial begin
        rsp_t r;
        forever begin
            @(negedge clk);
            if (resp_valid) begin
                if (rq.size() == 0) begin
                    chk("resp_unexpected", 64'd1, 64'd0);
                end else begin
                    r = rq.pop_front();
                    chk("resp_rdata", 64'(resp_rdata), 64'(r.rdata));
                    chk("resp_err", 64'(resp_err), 64'(r.err));
                    chk("resp_latency", 64'(cyc), 64'((r.err ? drive_cyc : raise_cyc) + 1));
                end
            end
        end
    end

    task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input int l);
        int          off, size, endb, t, j;
        logic        ill;
        rsp_t        r;
        beat_t       b;
        logic [31:0] v;
        off  = int'(a[1:0]);
        size = 1 << f3[1:0];
        endb = off + size;
        ill  = (f3 == 3'd7) || (f3 == 3'd3) || (f3 == 3'd6) || (st && f3[2]);
        v    = 32'h0;
        if (!ill && !st) begin
            for (int k = 0; k < size; k++) v[8*k +: 8] = rd_byte(a + 32'(k));
            if (!f3[2] && size < 4 && v[8*size-1])
                for (int k = size; k < 4; k++) v[8*k +: 8] = 8'hFF;
        end
        r.rdata = v;
        r.err   = ill;
        rq.push_back(r);
        if (!ill) begin
            b.addr = a & ~32'h3;
            b.wr   = st;
            for (int i = 0; i < 4; i++) begin
                j = i - off;
                b.be[i]          = (i >= off) && (i < endb);
                b.wdata[8*i +: 8] = (j >= 0 && j < 4) ? wd[8*j +: 8] : 8'h00;
            end
            bq.push_back(b);
            if (endb > 4) begin
                b.addr = (a & ~32'h3) + 32'd4;
                for (int i = 0; i < 4; i++) begin
                    j = i + 4 - off;
                    b.be[i]          = (i < endb - 4);
                    b.wdata[8*i +: 8] = (j < 4) ? wd[8*j +: 8] : 8'h00;
                end
                bq.push_back(b);
            end
        end
        lat = l;
        @(negedge clk);
        t = 0;
        while (!req_ready && t < 50) begin @(negedge clk); t++; end
        if (t >= 50) chk("ready_timeout", 64'd0, 64'd1);
        req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
        drive_cyc = cyc;
        @(negedge clk);
        req_valid = 1'b0;
        chk("busy_not_ready", 64'(req_ready), 64'd0);
        t = 0;
        while (rq.size() != 0 && t < 60) begin @(negedge clk); t++; end
        if (t >= 60) chk("resp_timeout", 64'd0, 64'd1);
        rq.delete();
        bq.delete();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'd0; req_addr = 32'h0; req_wdata = 32'h0;
        z_req_valid = 1'b0; z_req_store = 1'b0; z_req_funct3 = 3'd0; z_req_addr = 32'h0; z_req_wdata = 32'h0;
        z_mem_resp = 1'b0; z_mem_rdata = 32'h0;
        repeat (2) @(negedge clk);
        chk("rst_ready", 64'(req_ready), 64'd0);
        chk("rst_valid", 64'(resp_valid), 64'd0);
        chk("rst_err", 64'(resp_err), 64'd0);
        chk("rst_strobes", 64'({mem_read, mem_write}), 64'd0);
        chk("rst_addr", 64'(mem_address), 64'd0);
        chk("rst_be_wdata", {28'd0, mem_byte_enable, mem_wdata}, 64'd0);
        chk("rst_rdata", 64'(resp_rdata), 64'd0);
        chk("rst_ready_ns", 64'(z_req_ready), 64'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_rst", 64'(req_ready), 64'd1);

        set_word(32'h100, 32'hDEADBEEF);
        issue(1'b0, 3'b010, 32'h100, 32'h0, 2);
        set_word(32'h100, 32'h80FFFFFF);
        issue(1'b0, 3'b000, 32'h103, 32'h0, 1);
        issue(1'b0, 3'b100, 32'h103, 32'h0, 1);
        issue(1'b1, 3'b001, 32'h102, 32'h0000ABCD, 3);
        set_word(32'h0FC, 32'h2211AAAA);
        set_word(32'h100, 32'hBBBB4433);
        issue(1'b0, 3'b010, 32'h0FE, 32'h0, 1);
        issue(1'b0, 3'b011, 32'h100, 32'h0, 1);
        issue(1'b0, 3'b110, 32'h104, 32'h0, 0);
        issue(1'b1, 3'b100, 32'h104, 32'h55, 0);
        issue(1'b0, 3'b111, 32'h104, 32'h0, 0);
        issue(1'b1, 3'b010, 32'h0FF, 32'h11223344, 0);
        issue(1'b0, 3'b001, 32'h0FF, 32'h0, 2);
        issue(1'b0, 3'b101, 32'h0FF, 32'h0, 1);
        issue(1'b0, 3'b010, 32'hFFFFFFFE, 32'h0, 1);
        for (int n = 0; n < 40; n++)
            issue(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 32'($urandom_range(0, 300)),
                  32'($urandom), $urandom_range(0, 3));

        // Reset while the first beat of a load is outstanding.
        bq.push_back('{addr: 32'h200, be: 4'hF, wr: 1'b0, wdata: 32'h0});
        lat = 5;
        @(negedge clk);
        req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h200;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk("pre_rst_read", 64'(mem_read), 64'd1);
        #2 rst = 1'b0;
        #1;
        chk("abort_read", 64'(mem_read), 64'd0);
        chk("abort_ready", 64'(req_ready), 64'd0);
        chk("abort_addr", 64'(mem_address), 64'd0);
        repeat (3) @(negedge clk);
        chk("abort_no_valid", 64'(resp_valid), 64'd0);
        rst = 1'b1;
        bq.delete();
        @(posedge clk); #1;
        chk("abort_ready_after", 64'(req_ready), 64'd1);
        set_word(32'h200, 32'hCAFEF00D);
        issue(1'b0, 3'b010, 32'h200, 32'h0, 1);

        // SPLIT=0 instance: misaligned word is rejected without touching the bus.
        @(negedge clk);
        chk("ns_ready", 64'(z_req_ready), 64'd1);
        z_req_valid = 1'b1; z_req_store = 1'b0; z_req_funct3 = 3'b010; z_req_addr = 32'h0FE;
        @(negedge clk);
        z_req_valid = 1'b0;
        chk("ns_valid", 64'(z_resp_valid), 64'd1);
        chk("ns_err", 64'(z_resp_err), 64'd1);
        chk("ns_no_read", 64'({z_mem_read, z_mem_write}), 64'd0);
        chk("ns_rdata", 64'(z_resp_rdata), 64'd0);
        @(negedge clk);
        chk("ns_one_pulse", 64'(z_resp_valid), 64'd0);
        chk("ns_idle_ready", 64'(z_req_ready), 64'd1);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter XLEN, default 32: data word width; legal values are 32 and 64.
REQ-002 Parameter SPLIT, default 1: 1 splits misaligned accesses into two bus beats; 0 rejects them with an error.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst  in  1  reset; asynchronous, active-low.
REQ-005 req_valid  in  1  request present.
REQ-006 req_ready  out  1  unit can accept a request.
REQ-007 req_store  in  1  1 means store, 0 means load.
REQ-008 req_funct3  in  3  RV funct3: lb/sb=000, lh/sh=001, lw/sw=010, ld/sd=011, lbu=100, lhu=101, lwu=110.
REQ-009 req_addr  in  32  byte address.
REQ-010 req_wdata  in  XLEN  store data, right-justified.
REQ-011 resp_valid  out  1  one-cycle completion pulse.
REQ-012 resp_rdata  out  XLEN  extended load result.
REQ-013 resp_err  out  1  request rejected; qualified by resp_valid.
REQ-014 mem_read, mem_write  out  1 each  bus strobes.
REQ-015 mem_address  out  32  XLEN/8-aligned bus address.
REQ-016 mem_wdata  out  XLEN  lane-shifted store data.
REQ-017 mem_byte_enable  out  XLEN/8  byte-lane mask.
REQ-018 mem_rdata  in  XLEN  bus read data, valid while mem_resp=1.
REQ-019 mem_resp  in  1  bus beat complete.

Function
REQ-020 FSM states: IDLE, BEAT1, BEAT2, DONE; req_ready shall be 1 only in IDLE.
REQ-021 In IDLE, req_valid=1 shall capture all request fields; off = addr[log2(XLEN/8)-1:0], size = 1<<funct3[1:0] bytes.
REQ-022 Illegal requests shall go IDLE->DONE with resp_err=1 and no bus strobe; illegal means funct3=111, ld/lwu/sd with XLEN=32, a store with funct3[2]=1, or off+size>XLEN/8 with SPLIT=0.
REQ-023 Legal requests shall go to BEAT1 with mem_address = addr & ~(XLEN/8-1).
REQ-024 BEAT1 mask: lanes off to min(off+size, XLEN/8)-1; mem_wdata = wdata << 8*off (truncated to XLEN); loads drive the same mask.
REQ-025 mem_read/mem_write, address, wdata and mask shall hold constant in BEAT1/BEAT2 until mem_resp=1.
REQ-026 On mem_resp in BEAT1, mem_rdata shall be captured as beat0; next state is BEAT2 if off+size>XLEN/8, else DONE.
REQ-027 BEAT2 shall use address = aligned+XLEN/8 (mod 2^32), mask lanes 0 to off+size-XLEN/8-1, and wdata = the remaining upper bytes; on mem_resp it shall capture beat1 and go to DONE.
REQ-028 Load result = ({beat1,beat0} >> 8*off), truncated to size bytes, sign-extended for funct3[2]=0 and zero-extended otherwise; beat1 counts as 0 for unsplit accesses.
REQ-029 DONE shall assert resp_valid for exactly one cycle, then go to IDLE; resp_rdata shall be 0 for stores and errors and hold its value until the next DONE.
REQ-030 Latency: resp_valid rises the cycle after the final mem_resp; for errors, the cycle after acceptance.
REQ-031 mem_resp outside BEAT1/BEAT2 shall be ignored; at most one bus strobe is active at a time.

Reset
REQ-032 rst=0 shall immediately force state IDLE and drive req_ready, resp_valid, resp_err, mem_read and mem_write to 0; all data and address outputs go to 0.
REQ-033 Reset mid-transaction shall abort it: strobes drop asynchronously and no resp_valid is issued.
REQ-034 After rst is released, req_ready shall be 1 on the first clock edge.

Verification
REQ-035 XLEN=32, lw @0x100; mem_resp 2 cycles later with 0xDEADBEEF -> resp_rdata=0xDEADBEEF, resp_valid one cycle after mem_resp, one pulse.
REQ-036 lb @0x103, mem_rdata=0x80FFFFFF -> resp_rdata=0xFFFFFF80; lbu with the same stimulus -> 0x00000080.
REQ-037 sh @0x102, wdata=0x0000ABCD -> mem_address=0x100, mask=4'b1100, mem_wdata=0xABCD0000, mem_write held until mem_resp.
REQ-038 SPLIT=1, lw @0x0FE: beat 0x0FC, mask 1100, rdata 0x2211AAAA; beat 0x100, mask 0011, rdata 0xBBBB4433 -> resp_rdata=0x44332211.
REQ-039 SPLIT=0, lw @0x0FE, and separately ld with XLEN=32 -> resp_err=1, no mem_read, resp_valid the cycle after acceptance.
REQ-040 rst=0 during BEAT1 -> mem_read=0 before the next edge, no resp_valid; after release, req_ready=1 and a new lw completes normally.
